// File: rtl/mod5_acc_arb_pkg.sv
// Shared types and constants for the two-requester mod-5 one-hot accumulator.
package mod5_acc_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_t;

   localparam logic [4:0] ONEHOT_ZERO = 5'b00001;
   localparam int         NUM_REQ     = 2;

   // Residues travel one-hot; anything other than a single set bit is malformed.
   function automatic logic is_onehot5(input logic [4:0] v);
      case (v)
         5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000: return 1'b1;
         default:                                          return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mod5_acc_arb_add.sv
// One-hot mod-5 adder: adding value k is a left rotation of the one-hot vector by k.
module mod5_add
   import mod5_acc_arb_pkg::*;
(
   input  logic [4:0] i_a,
   input  logic [4:0] i_b,
   output logic [4:0] o_sum
);

   always_comb begin
      o_sum = ONEHOT_ZERO;
      case (i_b)
         5'b00001: o_sum = i_a;
         5'b00010: o_sum = {i_a[3:0], i_a[4]};
         5'b00100: o_sum = {i_a[2:0], i_a[4:3]};
         5'b01000: o_sum = {i_a[1:0], i_a[4:2]};
         5'b10000: o_sum = {i_a[0],   i_a[4:1]};
         default:  o_sum = ONEHOT_ZERO;
      endcase
   end

endmodule

// File: rtl/mod5_acc_arb.sv
// Round-robin arbiter feeding one shared mod-5 adder into two one-hot accumulators.
//   state   | meaning
//   ST_IDLE | grant offered to ReqValid per round-robin pointer; operand latched on handshake
//   ST_EXEC | shared adder evaluates acc[id] + operand; result written at the closing edge
module mod5_acc_arb
   import mod5_acc_arb_pkg::*;
#(
   parameter int CntWidth = 8
)
(
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic [1:0]              ReqValid,
   input  logic [9:0]              ReqData,
   output logic [1:0]              ReqReady,
   input  logic [1:0]              ReqClear,
   output logic [9:0]              AccOut,
   output logic                    OutValid,
   output logic                    OutId,
   output logic [4:0]              OutSum,
   output logic [2*CntWidth-1:0]   Cnt,
   output logic                    Err
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_ptr;
   logic [4:0]            r_acc [NUM_REQ];
   logic [CntWidth-1:0]   r_cnt [NUM_REQ];
   logic [4:0]            r_op;
   logic                  r_id;
   logic                  r_out_valid;
   logic                  r_out_id;
   logic [4:0]            r_out_sum;
   logic                  r_err;

   logic [1:0]            w_grant;
   logic                  w_hs;
   logic                  w_gnt_id;
   logic [4:0]            w_gnt_data;
   logic [4:0]            w_sum;
   logic                  w_op_ok;
   logic                  w_exec;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Grant is already qualified by ReqValid, so a nonzero grant is a handshake.
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 2'b00;
      case (r_state)
         ST_IDLE: begin
            if (ReqValid == 2'b11) w_grant = r_ptr ? 2'b10 : 2'b01;
            else                   w_grant = ReqValid;
            if (Reset)             w_grant = 2'b00;
            if (w_grant != 2'b00)  w_state_nxt = ST_EXEC;
         end
         ST_EXEC: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign ReqReady   = w_grant;
   assign w_hs       = |w_grant;
   assign w_gnt_id   = w_grant[1];
   assign w_gnt_data = w_gnt_id ? ReqData[9:5] : ReqData[4:0];
   assign w_exec     = (r_state == ST_EXEC);
   assign w_op_ok    = is_onehot5(r_op);

   mod5_add u_add (
      .i_a   (r_acc[r_id]),
      .i_b   (r_op),
      .o_sum (w_sum)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_ptr       <= 1'b0;
         r_op        <= ONEHOT_ZERO;
         r_id        <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_id    <= 1'b0;
         r_out_sum   <= ONEHOT_ZERO;
         r_err       <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            r_acc[i] <= ONEHOT_ZERO;
            r_cnt[i] <= '0;
         end
      end else begin
         r_out_valid <= 1'b0;
         if (w_hs) begin
            r_op  <= w_gnt_data;
            r_id  <= w_gnt_id;
            r_ptr <= ~w_gnt_id;
         end
         if (w_exec) begin
            if (w_op_ok) begin
               r_acc[r_id] <= w_sum;
               if (r_cnt[r_id] != '1) r_cnt[r_id] <= r_cnt[r_id] + CntWidth'(1);
               r_out_valid <= 1'b1;
               r_out_id    <= r_id;
               r_out_sum   <= w_sum;
            end else begin
               r_err <= 1'b1;
            end
         end
         // Clear is placed last so it overrides a same-edge accumulator write.
         for (int i = 0; i < NUM_REQ; i++) begin
            if (ReqClear[i]) begin
               r_acc[i] <= ONEHOT_ZERO;
               r_cnt[i] <= '0;
            end
         end
      end
   end

   assign AccOut   = {r_acc[1], r_acc[0]};
   assign Cnt      = {r_cnt[1], r_cnt[0]};
   assign OutValid = r_out_valid;
   assign OutId    = r_out_id;
   assign OutSum   = r_out_sum;
   assign Err      = r_err;

endmodule

// File: tb/tb_mod5_acc_arb.sv
// Self-checking bench for mod5_acc_arb: per-cycle vector table with a scoreboard of pending adds.
module tb_mod5_acc_arb;

   localparam int CW      = 2;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic              Clk = 1'b0;
   logic              Reset;
   logic [1:0]        ReqValid;
   logic [9:0]        ReqData;
   logic [1:0]        ReqReady;
   logic [1:0]        ReqClear;
   logic [9:0]        AccOut;
   logic              OutValid;
   logic              OutId;
   logic [4:0]        OutSum;
   logic [2*CW-1:0]   Cnt;
   logic              Err;

   mod5_acc_arb #(.CntWidth(CW)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .ReqValid (ReqValid),
      .ReqData  (ReqData),
      .ReqReady (ReqReady),
      .ReqClear (ReqClear),
      .AccOut   (AccOut),
      .OutValid (OutValid),
      .OutId    (OutId),
      .OutSum   (OutSum),
      .Cnt      (Cnt),
      .Err      (Err)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [1:0] valid;
      logic [9:0] data;
      logic [1:0] clear;
      logic [1:0] exp_ready;
   } vec_t;

   typedef struct {
      int         id;
      logic [4:0] op;
      int         due;
   } sb_t;

   vec_t vecs[$];
   sb_t  sbq[$];

   int   n_checks = 0;
   int   n_errors = 0;
   int   m_acc [2];
   int   m_cnt [2];
   logic m_err;
   int   cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic int oh2val(input logic [4:0] v);
      int r = -1;
      int n = 0;
      for (int k = 0; k < 5; k++) if (v[k]) begin r = k; n++; end
      return (n == 1) ? r : -1;
   endfunction

   function automatic logic [4:0] val2oh(input int v);
      logic [4:0] r = '0;
      r[v] = 1'b1;
      return r;
   endfunction

   function automatic logic [9:0] exp_acc();
      return {val2oh(m_acc[1]), val2oh(m_acc[0])};
   endfunction

   function automatic logic [31:0] exp_cnt();
      return 32'((m_cnt[1] << CW) | m_cnt[0]);
   endfunction

   task automatic check_state(input logic ov, input int id, input logic [4:0] sum);
      check("out_valid", 32'(OutValid), 32'(ov));
      if (ov) begin
         check("out_id",  32'(OutId),  32'(id));
         check("out_sum", 32'(OutSum), 32'(sum));
      end
      check("acc_out", 32'(AccOut), 32'(exp_acc()));
      check("cnt",     32'(Cnt),    exp_cnt());
      check("err",     32'(Err),    32'(m_err));
   endtask

   task automatic model_reset();
      m_acc[0] = 0; m_acc[1] = 0;
      m_cnt[0] = 0; m_cnt[1] = 0;
      m_err    = 1'b0;
      sbq.delete();
   endtask

   initial begin
      vec_t       v;
      sb_t        e;
      logic [1:0] hs;
      logic       exp_ov;
      int         exp_id;
      logic [4:0] exp_sum;
      int         val;

      // valid, data {r1,r0}, clear, expected ReqReady
      vecs.push_back('{2'b01, {5'b00000, 5'b01000}, 2'b00, 2'b01});
      vecs.push_back('{2'b01, {5'b00000, 5'b10000}, 2'b00, 2'b00});
      vecs.push_back('{2'b01, {5'b00000, 5'b10000}, 2'b00, 2'b01});
      vecs.push_back('{2'b00, 10'b0,                2'b00, 2'b00});
      vecs.push_back('{2'b00, 10'b0,                2'b00, 2'b00});
      for (int i = 0; i < 7; i++)
         vecs.push_back('{2'b11, {5'b00100, 5'b00010}, 2'b00,
                          (i % 4 == 0) ? 2'b10 : (i % 4 == 2) ? 2'b01 : 2'b00});
      vecs.push_back('{2'b00, 10'b0,                2'b00, 2'b00});
      vecs.push_back('{2'b00, 10'b0,                2'b00, 2'b00});
      vecs.push_back('{2'b10, {5'b00011, 5'b00000}, 2'b00, 2'b10});
      vecs.push_back('{2'b00, 10'b0,                2'b00, 2'b00});
      vecs.push_back('{2'b00, 10'b0,                2'b00, 2'b00});
      vecs.push_back('{2'b01, {5'b00000, 5'b00100}, 2'b00, 2'b01});
      vecs.push_back('{2'b00, 10'b0,                2'b01, 2'b00});
      vecs.push_back('{2'b00, 10'b0,                2'b00, 2'b00});
      vecs.push_back('{2'b11, {5'b10000, 5'b00001}, 2'b11, 2'b10});
      vecs.push_back('{2'b00, 10'b0,                2'b00, 2'b00});
      vecs.push_back('{2'b00, 10'b0,                2'b00, 2'b00});

      cyc      = 0;
      Reset    = 1'b1;
      ReqValid = 2'b11;
      ReqData  = {5'b00001, 5'b00001};
      ReqClear = 2'b00;
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      check("ready_in_reset", 32'(ReqReady), 32'd0);
      ReqValid = 2'b00;
      ReqData  = '0;
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      #1;
      check("reset_ready", 32'(ReqReady), 32'd0);
      check("reset_out_id",  32'(OutId),  32'd0);
      check("reset_out_sum", 32'(OutSum), 32'h01);
      check_state(1'b0, 0, 5'b0);
      @(posedge Clk);
      #1;

      foreach (vecs[n]) begin
         v        = vecs[n];
         ReqValid = v.valid;
         ReqData  = v.data;
         ReqClear = v.clear;
         #1;
         check("ready", 32'(ReqReady), 32'(v.exp_ready));
         hs      = v.valid & v.exp_ready;
         exp_ov  = 1'b0;
         exp_id  = 0;
         exp_sum = '0;
         if (sbq.size() > 0 && sbq[0].due == cyc + 1) begin
            e   = sbq.pop_front();
            val = oh2val(e.op);
            if (val >= 0) begin
               m_acc[e.id] = (m_acc[e.id] + val) % 5;
               if (m_cnt[e.id] < CNT_MAX) m_cnt[e.id]++;
               exp_ov  = 1'b1;
               exp_id  = e.id;
               exp_sum = val2oh(m_acc[e.id]);
            end else begin
               m_err = 1'b1;
            end
         end
         for (int i = 0; i < 2; i++)
            if (v.clear[i]) begin m_acc[i] = 0; m_cnt[i] = 0; end
         if (hs != 2'b00)
            sbq.push_back('{hs[1] ? 1 : 0, hs[1] ? v.data[9:5] : v.data[4:0], cyc + 2});
         @(posedge Clk);
         #1;
         cyc++;
         check_state(exp_ov, exp_id, exp_sum);
      end
      check("scoreboard_drained", 32'(sbq.size()), 32'd0);

      // Reset in the middle of EXEC aborts the add and re-arms the pointer to requester 0.
      ReqValid = 2'b01;
      ReqData  = {5'b00000, 5'b00010};
      ReqClear = 2'b00;
      #1;
      check("abort_ready", 32'(ReqReady), 32'b01);
      @(posedge Clk);
      #1;
      ReqValid = 2'b11;
      #2;
      Reset = 1'b1;
      model_reset();
      #1;
      check("abort_ready_in_reset", 32'(ReqReady), 32'd0);
      check_state(1'b0, 0, 5'b0);
      @(posedge Clk);
      #1;
      check_state(1'b0, 0, 5'b0);
      ReqValid = 2'b00;
      Reset    = 1'b0;
      @(posedge Clk);
      #1;
      check_state(1'b0, 0, 5'b0);
      ReqValid = 2'b11;
      ReqData  = {5'b00100, 5'b00010};
      #1;
      check("post_reset_ptr", 32'(ReqReady), 32'b01);
      @(posedge Clk);
      #1;
      ReqValid = 2'b00;
      @(posedge Clk);
      #1;
      m_acc[0] = 1;
      m_cnt[0] = 1;
      check_state(1'b1, 0, 5'b00010);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mod5_acc_arb.md
MOD5_ACC_ARB -- requirements
Module: mod5_acc_arb

Interface
REQ-001 Parameter: CntWidth, default 8, width of each per-requester accepted-operand counter.
REQ-002 Port: Clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 Port: Reset  in  1  asynchronous, active-high reset.
REQ-004 Port: ReqValid  in  2  per-requester operand valid; bit i belongs to requester i.
REQ-005 Port: ReqData  in  10  one-hot mod-5 operands; [4:0] requester 0, [9:5] requester 1; bit k set means value k.
REQ-006 Port: ReqReady  out  2  per-requester accept; a handshake occurs when ReqValid[i] and ReqReady[i] are both high.
REQ-007 Port: ReqClear  in  2  per-requester accumulator and counter clear.
REQ-008 Port: AccOut  out  10  one-hot accumulators; [4:0] requester 0, [9:5] requester 1.
REQ-009 Port: OutValid  out  1  one-cycle pulse marking a completed accumulation.
REQ-010 Port: OutId  out  1  requester index of the current OutValid pulse.
REQ-011 Port: OutSum  out  5  one-hot new accumulator value of the current OutValid pulse.
REQ-012 Port: Cnt  out  2*CntWidth  saturating accepted-valid-operand counts; low half requester 0.
REQ-013 Port: Err  out  1  sticky flag for a malformed operand.

Function
REQ-014 The FSM SHALL have two states: IDLE and EXEC.
REQ-015 In IDLE, the grant SHALL be a combinational function of ReqValid and the round-robin pointer; ReqReady SHALL be one-hot or zero and SHALL be zero in EXEC.
REQ-016 With both requesters valid, the grant SHALL go to the pointer requester; with one valid, it SHALL go to that requester.
REQ-017 On a grant, the pointer SHALL move to the other requester.
REQ-018 On a handshake, the operand and the requester id SHALL be registered and the FSM SHALL move to EXEC.
REQ-019 EXEC SHALL last exactly one cycle and SHALL then return to IDLE; throughput is one operand per 2 cycles.
REQ-020 In EXEC, the new accumulator SHALL be the mod-5 sum of the selected accumulator and the registered operand, formed by one shared adder.
REQ-021 At the end-of-EXEC edge, the accumulator and Cnt SHALL be written, OutSum and OutId SHALL be registered, and OutValid SHALL be high for exactly the following cycle.
REQ-022 Latency SHALL be: handshake in cycle N, then OutValid and the updated AccOut visible in cycle N+2.
REQ-023 An operand without exactly one bit set SHALL still be handshaken, then discarded: Err set, accumulator and Cnt unchanged, no OutValid, EXEC still consumed.
REQ-024 Each Cnt half SHALL saturate at 2^CntWidth-1.
REQ-025 ReqClear[i] SHALL set accumulator i to 5'b00001 and Cnt i to 0 at the next edge.
REQ-026 When ReqClear[i] coincides with an EXEC write to i, the clear SHALL win; OutValid and OutSum SHALL still report the computed sum.
REQ-027 ReqClear SHALL not affect arbitration, the pointer or Err.
REQ-028 Err SHALL clear only on Reset.

Reset
REQ-029 Reset SHALL asynchronously force: FSM to IDLE, pointer to requester 0, both accumulators to 5'b00001, Cnt 0, OutValid 0, OutId 0, OutSum 5'b00001, Err 0.
REQ-030 Reset asserted during EXEC SHALL abort the operation: no OutValid and no accumulator write.
REQ-031 ReqReady SHALL be 0 while Reset is high.

Structure
REQ-032 A shared package SHALL hold the FSM state typedef, the one-hot zero constant 5'b00001, and the requester count 2.
REQ-033 The block SHALL instantiate exactly one mod5_add as the shared adder sub-module; it SHALL contain no other arithmetic on the residues.

Verification
REQ-034 Reset, no ReqValid -> AccOut=10'b00001_00001, ReqReady=0, OutValid=0, Cnt=0.
REQ-035 Requester 0 sends 5'b01000 then 5'b10000 -> OutSum 5'b01000 then 5'b00100, OutId 0, Cnt low half 2, each OutValid two cycles after its handshake.
REQ-036 Both ReqValid held high with valid operands -> grants 0,1,0,1 on alternate cycles, one OutValid every 2 cycles.
REQ-037 Requester 1 sends 5'b00011 -> Err=1 and stays 1, AccOut[9:5] and Cnt unchanged, no OutValid.
REQ-038 ReqClear[0] in the EXEC cycle of a requester-0 add of value 2 -> OutSum shows the sum, then AccOut[4:0]=5'b00001 and Cnt low half 0.
REQ-039 CntWidth=2, 5 valid operands to requester 0 -> Cnt low half saturates at 3; Reset asserted mid-EXEC -> no OutValid.
